// File: rtl/compare_pkg.sv
// Shared types for the iterative magnitude comparator.
// Holds the FSM state encoding and the per-chunk result bundle.
package compare_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    typedef struct packed {
        logic eq;
        logic agt;
    } chunk_res_t;

endpackage

// File: rtl/compare_chunk.sv
// Combinational compare of one CHUNK-bit slice of A and B.
// inv_msb flips both sign bits so an unsigned compare orders two's-complement.
module compare_chunk
    import compare_pkg::*;
#(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             inv_msb,
    output chunk_res_t       res
);

    logic [CHUNK-1:0] flip;
    logic [CHUNK-1:0] a_m;
    logic [CHUNK-1:0] b_m;

    always_comb begin
        flip = '0;
        flip[CHUNK-1] = inv_msb;
    end

    assign a_m = a ^ flip;
    assign b_m = b ^ flip;

    always_comb begin
        res.eq  = (a_m == b_m);
        res.agt = (a_m > b_m);
    end

endmodule

// File: rtl/compare_iter.sv
// Iterative comparator: walks operand chunks from MSB down,
// stopping at the first unequal chunk.
module compare_iter
    import compare_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int CHUNK  = 4,
    parameter int NCHUNK = WIDTH / CHUNK,
    parameter int CW     = $clog2(NCHUNK + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             signed_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic             equal_o,
    output logic             alarger_o,
    output logic             blarger_o,
    output logic [CW-1:0]    cycles_o
);

    localparam int IW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    state_t state;
    state_t state_nx;

    logic [IW-1:0]    idx;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             sgn_q;

    logic [NCHUNK-1:0][CHUNK-1:0] a_v;
    logic [NCHUNK-1:0][CHUNK-1:0] b_v;
    logic             top_chunk;
    logic             last_chunk;
    chunk_res_t       res;

    assign a_v = a_q;
    assign b_v = b_q;
    assign top_chunk  = (idx == IW'(NCHUNK - 1));
    assign last_chunk = (idx == '0);

    compare_chunk #(
        .CHUNK (CHUNK)
    ) u_chunk (
        .a       (a_v[idx]),
        .b       (b_v[idx]),
        .inv_msb (sgn_q & top_chunk),
        .res     (res)
    );

    assign ready_o = (state == IDLE);
    assign valid_o = (state == DONE);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (valid_i) state_nx = BUSY;
            BUSY: if (!res.eq || last_chunk) state_nx = DONE;
            DONE: if (ready_i) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Operand capture, chunk walk and result registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            a_q       <= '0;
            b_q       <= '0;
            sgn_q     <= 1'b0;
            idx       <= '0;
            cnt       <= '0;
            equal_o   <= 1'b0;
            alarger_o <= 1'b0;
            blarger_o <= 1'b0;
            cycles_o  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (valid_i) begin
                        a_q   <= a_i;
                        b_q   <= b_i;
                        sgn_q <= signed_i;
                        idx   <= IW'(NCHUNK - 1);
                        cnt   <= '0;
                    end
                end
                BUSY: begin
                    cnt <= cnt + CW'(1);
                    if (!res.eq) begin
                        equal_o   <= 1'b0;
                        alarger_o <= res.agt;
                        blarger_o <= ~res.agt;
                        cycles_o  <= cnt + CW'(1);
                    end else if (last_chunk) begin
                        equal_o   <= 1'b1;
                        alarger_o <= 1'b0;
                        blarger_o <= 1'b0;
                        cycles_o  <= cnt + CW'(1);
                    end else begin
                        idx <= idx - IW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/compare_iter.md
COMPARE_ITER -- requirements
Module: compare_iter

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand width in bits.
REQ-002 SHALL have parameter CHUNK, default 4, bits compared per cycle; WIDTH % CHUNK == 0 and WIDTH >= CHUNK are required, with NCHUNK = WIDTH/CHUNK.
REQ-003 SHALL use one clock and an asynchronous, active-high reset.
REQ-004 SHALL have port clk_i, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_i, input, 1 bit, asynchronous active-high reset.
REQ-006 SHALL have port valid_i, input, 1 bit, request valid.
REQ-007 SHALL have port ready_o, output, 1 bit, block can accept a request.
REQ-008 SHALL have port a_i, input, WIDTH bits, operand A.
REQ-009 SHALL have port b_i, input, WIDTH bits, operand B.
REQ-010 SHALL have port signed_i, input, 1 bit, 1 = two's-complement compare, 0 = unsigned.
REQ-011 SHALL have port valid_o, output, 1 bit, result valid.
REQ-012 SHALL have port ready_i, input, 1 bit, consumer accepts result.
REQ-013 SHALL have port equal_o, output, 1 bit, A == B.
REQ-014 SHALL have port alarger_o, output, 1 bit, A > B.
REQ-015 SHALL have port blarger_o, output, 1 bit, B > A.
REQ-016 SHALL have port cycles_o, output, $clog2(NCHUNK+1) bits, number of chunks examined for the current result.

Function
REQ-017 SHALL implement a three-state FSM with states IDLE, BUSY and DONE.
REQ-018 In IDLE: ready_o=1; valid_i&ready_o at an edge latches a_i, b_i and signed_i, sets chunk index idx=NCHUNK-1, clears the chunk counter, and goes to BUSY.
REQ-019 In BUSY: each cycle compares chunk idx (bits idx*CHUNK+CHUNK-1 : idx*CHUNK) of the latched operands and increments the chunk counter.
REQ-020 Signed mode: for idx==NCHUNK-1 the MSB of both chunks is inverted before comparison; no effect in unsigned mode.
REQ-021 Chunk unequal: register alarger/blarger per the chunk result and go to DONE (early termination).
REQ-022 Chunk equal with idx==0: register equal and go to DONE; chunk equal with idx>0: idx decrements and the FSM stays in BUSY.
REQ-023 Latency: valid_o rises exactly n cycles after the accept edge, where n = chunks examined, 1 <= n <= NCHUNK; cycles_o = n.
REQ-024 In DONE: valid_o=1; equal_o, alarger_o, blarger_o and cycles_o are stable until valid_o&ready_i at an edge, which returns the FSM to IDLE.
REQ-025 While valid_o=1, exactly one of equal_o, alarger_o and blarger_o SHALL be 1.
REQ-026 ready_o=0 in BUSY and DONE; valid_i in those states SHALL be ignored with no effect on state.
REQ-027 Input operands SHALL be sampled only at the accept edge; later changes to a_i, b_i and signed_i SHALL NOT affect the result.
REQ-028 Result outputs SHALL change only on transition into DONE and SHALL hold their last values in IDLE and BUSY.

Reset
REQ-029 rst_i=1 SHALL immediately force IDLE, independent of clk_i.
REQ-030 Reset values SHALL be: valid_o=0, equal_o=0, alarger_o=0, blarger_o=0, cycles_o=0, internal idx=0 and operand registers=0.
REQ-031 Reset in BUSY or DONE SHALL discard the in-flight request; ready_o=1 on the first edge after rst_i deasserts.

Structure
REQ-032 Shared package compare_pkg SHALL hold the FSM state enum (IDLE, BUSY, DONE) and the typedef of the per-chunk result (eq, agt).
REQ-033 Sub-module compare_chunk, parametrised by CHUNK, SHALL be purely combinational, producing eq and agt for one chunk, and SHALL be instantiated once and muxed by idx.
REQ-034 The FSM, idx counter, chunk counter and result registers SHALL reside in compare_iter.

Verification (WIDTH=32, CHUNK=4)
REQ-035 Unsigned a=0x8000_0000, b=0x7FFF_FFFF -> alarger_o=1, cycles_o=1, valid_o 1 cycle after accept.
REQ-036 Signed, same operands -> blarger_o=1, cycles_o=1.
REQ-037 a=b=0x1234_5678, either mode -> equal_o=1, cycles_o=8, valid_o 8 cycles after accept.
REQ-038 Unsigned a=0x0000_0010, b=0x0000_0001 -> alarger_o=1, cycles_o=7; signed a=0xFFFF_FFFF, b=0x0000_0000 -> blarger_o=1, cycles_o=1.
REQ-039 Result with ready_i held 0 for 3 cycles plus valid_i pulses and operand changes -> outputs stable and ready_o=0 throughout; IDLE one cycle after ready_i=1.
REQ-040 rst_i pulsed mid-BUSY (between edges) -> valid_o=0 and ready_o=1 asynchronously; the next request completes correctly.
